// File: rtl/icache_axi_rd_pkg.sv
// Shared types and AXI constants for the instruction-cache AXI read bridge.
package icache_axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] ARCACHE_WB = 4'b1111;
    localparam logic [3:0] ARCACHE_UC = 4'b0000;
    localparam logic [2:0] PROT_INSN  = 3'b100;

    typedef struct packed {
        logic [31:0] addr;
        logic        uncached;
    } req_t;

endpackage

// File: rtl/icache_axi_rd_if.sv
// AXI4 read-channel bundle (AR + R) between the bridge and the interconnect.
interface icache_axi_rd_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_axi_rd.sv
// AXI4 read master for I-cache refills (4-beat INCR) and uncached fetches (1 beat);
// gathers R beats into one line-wide return word with a single-cycle ret_valid.
//
// state | meaning
// IDLE  | ready for a request, rd_rdy high
// AR    | arvalid high, address fields held from request regs
// R     | rready high, collecting beats until rlast
// DONE  | ret_valid pulse, bus_err reports accumulated error
module icache_axi_rd
    import icache_axi_rd_pkg::*;
#(
    parameter int LINE_WORD_NUM = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int ARID_VAL      = 0
) (
    input  logic                                clk_g,
    input  logic                                rst,
    input  logic                                rd_req,
    input  logic                                rd_uncache,
    input  logic [31:0]                         rd_addr,
    output logic                                rd_rdy,
    output logic                                ret_valid,
    output logic [LINE_WORD_NUM*DATA_WIDTH-1:0] ret_data,
    output logic                                bus_err,
    icache_axi_rd_if.master                     axi
);

    localparam int CNT_W = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST_SLOT = cnt_t'(LINE_WORD_NUM - 1);

    state_t state;
    req_t   req;
    cnt_t   beat_cnt;
    logic   last_filled;
    logic   err_flag;
    logic   arvalid_q;
    logic   rready_q;

    cnt_t   slot;
    cnt_t   exp_last;
    logic   beat_err;
    logic   len_err;

    assign axi.arid    = ID_WIDTH'(ARID_VAL);
    assign axi.araddr  = req.addr;
    assign axi.arlen   = req.uncached ? 8'd0 : 8'(LINE_WORD_NUM - 1);
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = req.uncached ? ARCACHE_UC : ARCACHE_WB;
    assign axi.arprot  = PROT_INSN;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    // Uncached data always lands in the top slot, where the cache looks for it.
    always_comb begin
        slot     = req.uncached ? LAST_SLOT : beat_cnt;
        exp_last = req.uncached ? '0 : LAST_SLOT;
        beat_err = (axi.rresp != RESP_OKAY) || last_filled;
        len_err  = axi.rlast && (last_filled || (beat_cnt != exp_last));
    end

    always_ff @(posedge clk_g) begin
        if (rst) begin
            state       <= IDLE;
            req         <= '0;
            beat_cnt    <= '0;
            last_filled <= 1'b0;
            err_flag    <= 1'b0;
            rd_rdy      <= 1'b1;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ret_valid   <= 1'b0;
            bus_err     <= 1'b0;
            ret_data    <= '0;
        end else begin
            ret_valid <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req && rd_rdy) begin
                        req         <= '{addr: rd_addr, uncached: rd_uncache};
                        beat_cnt    <= '0;
                        last_filled <= 1'b0;
                        err_flag    <= 1'b0;
                        ret_data    <= '0;
                        rd_rdy      <= 1'b0;
                        arvalid_q   <= 1'b1;
                        state       <= AR;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (axi.rvalid) begin
                        ret_data[int'(slot)*DATA_WIDTH +: DATA_WIDTH] <= axi.rdata;
                        // Counter saturates; only rlast ends the burst.
                        if (beat_cnt != LAST_SLOT) beat_cnt <= beat_cnt + 1'b1;
                        else                       last_filled <= 1'b1;
                        if (beat_err || len_err) err_flag <= 1'b1;
                        if (axi.rlast) begin
                            rready_q  <= 1'b0;
                            ret_valid <= 1'b1;
                            bus_err   <= err_flag || beat_err || len_err;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    rd_rdy <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
